// File: rtl/audio_pkg.sv
// Shared definitions for the audio path: sample width, I2S slot geometry,
// the silence value and the signed sample type.
package audio_pkg;

    localparam int AUDIO_W         = 16;
    localparam int SLOTS_PER_FRAME = 32;
    localparam int SLOTS_PER_CH    = 16;
    localparam int SLOT_W          = $clog2(SLOTS_PER_FRAME);

    localparam logic [AUDIO_W-1:0] AUDIO_SILENCE = 16'h0000;

    typedef logic signed [AUDIO_W-1:0] sample_t;

    // Slot s carries frame bit 32-s. Modulo 32 that is simply -s, which
    // also gives bit 0 for slot 0.
    function automatic logic [SLOT_W-1:0] frameBitIndex(input logic [SLOT_W-1:0] slot);
        return SLOT_W'(0) - slot;
    endfunction

endpackage

// File: rtl/audio_clk_gen.sv
// Free-running frame counter for the I2S transmitter.
// MCLK, LRCK and SCK are taken straight from counter flops, so they are glitch-free.
// The block also reports the current slot, the first clk of each slot,
// the last clk of each slot and the last clk of the frame.
module audio_clk_gen
    import audio_pkg::*;
#(
    parameter int MCLK_DIV   = 4,
    parameter int LRCK_RATIO = 256
)
(
    input  logic              clk,
    input  logic              rst,
    output logic              o_mclk,
    output logic              o_lrck,
    output logic              o_sck,
    output logic [SLOT_W-1:0] o_slot,
    output logic              o_slotStart,
    output logic              o_slotLast,
    output logic              o_frameWrap
);

    localparam int CW = $clog2(MCLK_DIV * LRCK_RATIO);
    localparam int MW = $clog2(MCLK_DIV);
    localparam int PW = CW - SLOT_W;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] r_cnt;

    // Counter advances every clk and wraps naturally at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    assign o_mclk      = r_cnt[MW-1];
    assign o_lrck      = r_cnt[CW-1];
    assign o_sck       = r_cnt[PW-1];
    assign o_slot      = r_cnt[CW-1:PW];
    assign o_slotStart = (r_cnt[PW-1:0] == '0);
    assign o_slotLast  = &r_cnt[PW-1:0];
    assign o_frameWrap = &r_cnt;

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter for the stereo Pmod DAC.
// Captures one left/right pair per frame and shifts it out MSB-first,
// using the standard I2S one-bit delay relative to LRCK.
// Optional build macro AUDIO_I2S_TX_MONO_MIX_EN: when defined, both channels
// carry the floor average of the two inputs.
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int MCLK_DIV   = 4,
    parameter int LRCK_RATIO = 256
)
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [AUDIO_W-1:0] audio_left,
    input  logic signed [AUDIO_W-1:0] audio_right,
    output logic                      sample_req,
    output logic                      audio_mclk,
    output logic                      audio_lrck,
    output logic                      audio_sck,
    output logic                      audio_sdin
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS_PER_FRAME - 1);
    localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);

    logic [SLOT_W-1:0]    w_slot;
    logic [SLOT_W-1:0]    w_nextSlot;
    logic [SLOT_W-1:0]    w_bitIdx;
    logic                 w_slotStart;
    logic                 w_slotLast;
    logic                 w_frameWrap;
    logic [2*AUDIO_W-1:0] w_frame;
    logic                 w_nextBit;
    sample_t              w_capLeft;
    sample_t              w_capRight;

    sample_t r_leftHold;
    sample_t r_rightHold;
    logic    r_prevLsb;
    logic    r_sdin;
    logic    r_sampleReq;

    audio_clk_gen #(
        .MCLK_DIV   (MCLK_DIV),
        .LRCK_RATIO (LRCK_RATIO)
    ) u_clkGen (
        .clk         (clk),
        .rst         (rst),
        .o_mclk      (audio_mclk),
        .o_lrck      (audio_lrck),
        .o_sck       (audio_sck),
        .o_slot      (w_slot),
        .o_slotStart (w_slotStart),
        .o_slotLast  (w_slotLast),
        .o_frameWrap (w_frameWrap)
    );

`ifdef AUDIO_I2S_TX_MONO_MIX_EN
    // A 17-bit sum of two sign-extended samples cannot overflow, and halving
    // it always fits back into 16 bits.
    logic signed [AUDIO_W:0] w_mixSum;
    assign w_mixSum   = $signed({audio_left[AUDIO_W-1], audio_left})
                      + $signed({audio_right[AUDIO_W-1], audio_right});
    assign w_capLeft  = AUDIO_W'(w_mixSum >>> 1);
    assign w_capRight = AUDIO_W'(w_mixSum >>> 1);
`else
    assign w_capLeft  = audio_left;
    assign w_capRight = audio_right;
`endif

    assign w_frame    = {r_leftHold, r_rightHold};
    assign w_nextSlot = w_slot + SLOT_ONE;
    assign w_bitIdx   = frameBitIndex(w_nextSlot);
    assign w_nextBit  = (w_nextSlot == '0) ? r_prevLsb : w_frame[w_bitIdx];

    // Latch a new sample pair on the edge where the counter wraps to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_leftHold  <= AUDIO_SILENCE;
            r_rightHold <= AUDIO_SILENCE;
        end else if (w_frameWrap) begin
            r_leftHold  <= w_capLeft;
            r_rightHold <= w_capRight;
        end
    end

    // Save the outgoing right LSB before the capture overwrites the hold register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prevLsb <= 1'b0;
        end else if (w_slotStart && (w_slot == LAST_SLOT)) begin
            r_prevLsb <= r_rightHold[0];
        end
    end

    // Load the next slot's bit on the last clk of a slot, so the pin changes
    // together with the SCK falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sdin <= 1'b0;
        end else if (w_slotLast) begin
            r_sdin <= w_nextBit;
        end
    end

    // Pulse during the cnt==0 cycle, right after a capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sampleReq <= 1'b0;
        end else begin
            r_sampleReq <= w_frameWrap;
        end
    end

    assign audio_sdin = r_sdin;
    assign sample_req = r_sampleReq;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Testbench for audio_i2s_tx.
// A frame-level reference model queues the expected bit for every slot.
// A monitor pops one entry on each SCK rising edge and compares it.
// Clock taps, sample_req and sdin stability are checked every cycle.
module tb_audio_i2s_tx;

    localparam int FRAME_CLKS = 1024;
    localparam int SLOT_CLKS  = 32;
    localparam int MCLK_CLKS  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [15:0] audio_left  = 16'sh0000;
    logic signed [15:0] audio_right = 16'sh0000;
    logic sample_req;
    logic audio_mclk;
    logic audio_lrck;
    logic audio_sck;
    logic audio_sdin;

    typedef struct {
        logic bitVal;
        int   slot;
        int   frame;
    } sdin_exp_t;

    sdin_exp_t sbQ[$];

    int   assertCount = 0;
    int   failCount   = 0;
    int   phase       = 0;
    int   frameNum    = 0;
    bit   modelActive = 1'b0;
    bit   justReset   = 1'b0;
    bit   reqExp      = 1'b0;
    bit   prevLsb     = 1'b0;
    logic slotSdin    = 1'b0;
    logic [31:0] captured;

    audio_i2s_tx dut (
        .clk         (clk),
        .rst         (rst),
        .audio_left  (audio_left),
        .audio_right (audio_right),
        .sample_req  (sample_req),
        .audio_mclk  (audio_mclk),
        .audio_lrck  (audio_lrck),
        .audio_sck   (audio_sck),
        .audio_sdin  (audio_sdin)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // The 32-bit word a frame carries for the given input pair.
    function automatic logic [31:0] frameWord(input logic signed [15:0] l, input logic signed [15:0] r);
`ifdef AUDIO_I2S_TX_MONO_MIX_EN
        int a;
        int b;
        int m;
        a = l;
        b = r;
        m = (a + b) >>> 1;
        return {m[15:0], m[15:0]};
`else
        return {l, r};
`endif
    endfunction

    // Queue the 32 slot bits of one frame: slot 0 repeats the previous LSB,
    // then the word goes out MSB-first.
    task automatic pushFrame(input logic [31:0] f, input bit lsb);
        sdin_exp_t e;
        for (int s = 0; s < 32; s++) begin
            e.bitVal = (s == 0) ? lsb : f[32 - s];
            e.slot   = s;
            e.frame  = frameNum;
            sbQ.push_back(e);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r);
        audio_left  = l;
        audio_right = r;
    endtask

    task automatic waitPhase(input int target);
        for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
            @(negedge clk);
            if (phase == target) return;
        end
        assertCount++;
        failCount++;
        $display("[TB] FAIL waitPhase: got no phase %0d, expected it within %0d cycles", target, 2 * FRAME_CLKS);
    endtask

    // Reference model: track the frame phase and issue the expected bits at each capture.
    always @(posedge clk) begin
        if (rst) begin
            phase       = 0;
            frameNum    = 0;
            modelActive = 1'b1;
            justReset   = 1'b1;
            reqExp      = 1'b0;
            prevLsb     = 1'b0;
            sbQ.delete();
            pushFrame(32'h0, 1'b0);
        end else if (modelActive) begin
            justReset = 1'b0;
            phase     = (phase + 1) % FRAME_CLKS;
            reqExp    = (phase == 0);
            if (phase == 0) begin
                frameNum++;
                captured = frameWord(audio_left, audio_right);
                pushFrame(captured, prevLsb);
                prevLsb = captured[0];
            end
        end
    end

    // Per-cycle checks of clock taps, sample_req, reset values and sdin stability.
    always @(negedge clk) begin
        if (modelActive) begin
            checkOutput("sampleReq", sample_req, reqExp);
            checkOutput("mclk", audio_mclk, (phase % MCLK_CLKS) >= MCLK_CLKS / 2);
            checkOutput("sck", audio_sck, (phase % SLOT_CLKS) >= SLOT_CLKS / 2);
            checkOutput("lrck", audio_lrck, phase >= FRAME_CLKS / 2);
            if (justReset) begin
                checkOutput("sdinAfterReset", audio_sdin, 1'b0);
            end
            if ((phase % SLOT_CLKS) == 0) begin
                slotSdin = audio_sdin;
            end else begin
                checkOutput("sdinStable", audio_sdin, slotSdin);
            end
        end
    end

    // Monitor: each SCK rising edge presents one serial bit.
    always begin
        @(posedge audio_sck);
        @(negedge clk);
        if (modelActive) begin
            if (sbQ.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL sdinUnderflow: got an SCK edge with nothing queued, expected a queued bit");
            end else begin
                sdin_exp_t e;
                e = sbQ.pop_front();
                checkOutput($sformatf("sdin frame%0d slot%0d", e.frame, e.slot), audio_sdin, e.bitVal);
            end
        end
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: got no end of test, expected one before the time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(16'h0000, 16'h0000);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        $display("[TB] reset released");

        // Frame 1 is silence, frame 2 carries B000/5FFF.
        applyStimulus(16'hB000, 16'h5FFF);
        waitPhase(0);
        waitPhase(0);

        // A mid-frame change is only picked up at the next capture.
        waitPhase(300);
        applyStimulus(16'h1234, 16'h5FFF);
        waitPhase(0);

        // Capture-edge timing around the wrap.
        applyStimulus(16'hA5A5, 16'h0F0F);
        waitPhase(1023);
        applyStimulus(16'h7ACE, 16'h8001);
        waitPhase(0);
        applyStimulus(16'h1111, 16'h2222);
        waitPhase(0);

        // Reset in slot 10; the restarted frame is silent.
        waitPhase(10 * SLOT_CLKS + 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(16'h5FFF, 16'hB000);
        waitPhase(0);
        applyStimulus(16'h8000, 16'h8000);
        waitPhase(0);
        waitPhase(0);

        // Random pairs at random phases.
        for (int f = 0; f < 6; f++) begin
            waitPhase($urandom_range(1, FRAME_CLKS - 2));
            applyStimulus(16'($urandom), 16'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                waitPhase(FRAME_CLKS - 1);
                applyStimulus(16'($urandom), 16'($urandom));
            end
            waitPhase(0);
        end

        // Only slot 0 of the current frame has been consumed at this point.
        waitPhase(40);
        checkOutput("scoreboardLevel", sbQ.size(), 31);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
- I2S transmitter for the stereo Pmod DAC.
- Takes 16-bit signed left/right samples from the tone generator and serializes them MSB-first in standard I2S format.
- Generates MCLK, LRCK and SCK as bits of one free-running counter.
- Sits between the note/tone source and the board's audio pins; emits a per-frame sample request so upstream knows when its samples were consumed.

Parameters:
- MCLK_DIV, 4, clk cycles per MCLK period; power of two, at least 2.
- LRCK_RATIO, 256, MCLK periods per LRCK period; power of two; MCLK_DIV*LRCK_RATIO must be at least 64.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  reset, synchronous, active-high.
- audio_left  in  16  signed left sample, two's complement.
- audio_right  in  16  signed right sample, two's complement.
- sample_req  out  1  one-cycle pulse; inputs were captured on the preceding edge.
- audio_mclk  out  1  master clock, clk/MCLK_DIV.
- audio_lrck  out  1  word select; 0 = left, 1 = right.
- audio_sck  out  1  serial bit clock, 32 per LRCK period.
- audio_sdin  out  1  serial data.

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous, active-high.
- Counter: cnt of width CW = log2(MCLK_DIV*LRCK_RATIO), 10 bits at defaults; increments every clk and wraps to 0.
- Clock outputs, taken directly from cnt flops so they are glitch-free:
  - audio_mclk = cnt[log2(MCLK_DIV)-1]
  - audio_lrck = cnt[CW-1]
  - audio_sck = cnt[CW-6]
  - Defaults: MCLK period 4 clk, SCK period 32 clk, LRCK period 1024 clk; all 50% duty.
- Slot: slot = cnt[CW-1:CW-5], values 0..31, one SCK period each.
  - Slot boundaries coincide with SCK falling edges.
  - Left half is slots 0..15, right half is slots 16..31.
- Capture: on the edge where cnt goes from all-ones to 0, left_hold <= audio_left and right_hold <= audio_right.
  - Frame word F = {left_hold, right_hold}.
  - sample_req = 1 exactly during the cycle cnt == 0; 0 otherwise.
  - Input changes at any other time are ignored until the next capture edge.
- Serial data, I2S one-bit delay:
  - In slot s, for s = 1..31: audio_sdin = F[32-s].
  - In slot 0: audio_sdin = F[0] of the previous frame (right LSB), held in a separate prev_lsb flop.
  - audio_sdin is registered and changes only in the first clk of a slot (SCK falling). It is stable across the SCK rising edge mid-slot.
- Latency: a sample captured at cnt 0 has its left MSB on the pin at slot 1, 32 clk later at defaults.
- Reset values: cnt = 0, left_hold = right_hold = 0, prev_lsb = 0, audio_sdin = 0, sample_req = 0. Hence mclk = lrck = sck = 0.
- After reset release:
  - The first frame transmits all zeros, with sample_req held low.
  - The first capture occurs at the first wrap, 1024 clk later.
- Reset mid-frame: takes effect on the next clk edge; the partial frame is discarded and the sequence restarts exactly as after power-up.
- No handshake stall: the upstream block must present valid samples continuously. The block never waits.

Optional Feature:
- Macro: AUDIO_I2S_TX_MONO_MIX_EN.
- Defined: at capture, m = (sext17(audio_left) + sext17(audio_right)) >>> 1 (arithmetic shift, floor); left_hold = right_hold = m[15:0]. The result never overflows.
- Undefined: independent stereo, as described in Behaviour. No mixing logic is synthesized.

Decomposition:
- Shared package audio_pkg:
  - AUDIO_W = 16
  - SLOTS_PER_FRAME = 32
  - SLOTS_PER_CH = 16
  - Silence constant 16'h0000
  - Typedef for the signed 16-bit sample
- One sub-module, audio_clk_gen: owns cnt, the mclk/lrck/sck taps, and emits slot, slot_start (first clk of slot) and frame_wrap (cnt all-ones).
- Top level owns the hold registers, prev_lsb, the sdin flop, sample_req and the optional mixer.

Test Plan:
1. Reset and clocks: rst=1 for 5 clk -> all outputs 0. After release -> mclk period 4, sck period 32, lrck period 1024, all 50% duty; lrck rises at clk 512.
2. Serial data: hold L=16'hB000, R=16'h5FFF, sample on sck rising -> frame 2 slots 1..16 = 1011_0000_0000_0000, slots 17..31 = 5FFF[15:1], slot 0 of frame 3 = 1.
3. sample_req: -> exactly one pulse per 1024 clk, each at cnt==0. Changing L to 16'h1234 at cnt==300 -> the old value is still sent this frame and 1234 is sent next frame.
4. Capture-edge timing: change inputs in the cnt==0 cycle -> not captured until the following frame. Change inputs in the cnt==1023 cycle -> captured.
5. Reset mid-frame: assert rst at slot 10 for 1 clk -> outputs 0 on the next cycle; next frame transmits zeros (prev_lsb cleared); first sample_req 1024 clk after release.
6. AUDIO_I2S_TX_MONO_MIX_EN defined:
   - L=16'h5FFF, R=16'hB000 -> both halves 16'h07FF.
   - L=R=16'h8000 -> both halves 16'h8000.
   - Undefined, same stimulus -> 5FFF / B000 unchanged.
